// File: rtl/vn_packer.sv
// Von Neumann debiaser: folds each accepted sum word to one parity bit, whitens
// bit pairs, packs the surviving bits MSB-first into bytes and queues them in a FWFT FIFO.
module vn_packer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [31:0]                   sum_in,
  input  logic                          sum_valid,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HALF  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_first;
  logic [7:0]      r_shreg;
  logic [2:0]      r_cnt;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic            r_overflow;

  logic            w_accept;
  logic            w_f;
  logic            w_emit;
  logic            w_bit;
  logic            w_byte_done;
  logic [7:0]      w_byte;
  logic            w_pop;
  logic            w_push_ok;

  assign w_accept    = en & sum_valid;
  assign w_f         = ^sum_in;
  assign w_byte_done = w_emit && (r_cnt == 3'd7);
  assign w_byte      = {r_shreg[6:0], w_bit};
  assign w_pop       = (r_level != '0) && byte_ready;
  // A full FIFO can still take the new byte when the head leaves in the same edge.
  assign w_push_ok   = w_byte_done && ((r_level < LW'(FIFO_DEPTH)) || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_bit       = r_first;
    if (w_accept) begin
      case (r_state)
        S_EMPTY: w_state_nxt = S_HALF;
        S_HALF: begin
          w_state_nxt = S_EMPTY;
          w_emit      = (r_first != w_f);
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_first <= 1'b0;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && (r_state == S_EMPTY)) begin
        r_first <= w_f;
      end
      if (w_emit) begin
        r_shreg <= w_byte;
        r_cnt   <= r_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push_ok) begin
        r_level <= r_level - LW'(1);
      end
      if (w_byte_done && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wptr] <= w_byte;
    end
  end

  assign byte_out   = r_mem[r_rptr];
  assign byte_valid = (r_level != '0);
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_vn_packer.sv
// Directed bench for vn_packer: pair whitening, byte packing, FIFO fill/overflow,
// reset mid-operation and enable freeze.
module tb_vn_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] sum_in;
  logic        sum_valid;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic [2:0]  fifo_level;
  logic        overflow;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  vn_packer #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sum_in     (sum_in),
    .sum_valid  (sum_valid),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted word whose parity is p.
  task automatic word(input logic p);
    sum_in    = p ? 32'h0000_0001 : 32'h0000_0000;
    sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
  endtask

  task automatic pair(input logic a, input logic b);
    word(a);
    word(b);
  endtask

  // Emit bits b[hi] downto b[lo]; (1,0) emits 1, (0,1) emits 0.
  task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      pair(b[i], ~b[i]);
    end
  endtask

  // Emit a whole byte; optionally pop in the cycle the byte completes.
  task automatic send_byte(input logic [7:0] b, input logic pop_last);
    send_bits(b, 7, 1);
    word(b[0]);
    byte_ready = pop_last;
    word(~b[0]);
    byte_ready = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {31'b0, byte_valid}, 32'd1);
    chk({tag, "_data"}, {24'b0, byte_out}, {24'b0, exp});
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sum_in = '0; sum_valid = 1'b0; byte_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, byte_valid}, 32'd0);
    chk("rst_level", {29'b0, fifo_level}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    rst = 1'b0;

    // Eight (1,0) pairs -> 0xFF, visible one cycle after the 16th word
    send_bits(8'hFF, 7, 1);
    word(1'b1);
    chk("pair_pre_valid", {31'b0, byte_valid}, 32'd0);
    word(1'b0);
    chk("pair_level", {29'b0, fifo_level}, 32'd1);
    pop_check("pair", 8'hFF);
    chk("pair_drained", {29'b0, fifo_level}, 32'd0);

    // Equal pairs are discarded
    for (int i = 0; i < 4; i++) begin
      sum_in = 32'h3; sum_valid = 1'b1; tick();
      tick();
      pair(1'b1, 1'b1);
    end
    sum_valid = 1'b0;
    chk("disc_valid", {31'b0, byte_valid}, 32'd0);
    chk("disc_cnt", {29'b0, dut.r_cnt}, 32'd0);

    // Alternating pairs -> 0xAA
    send_byte(8'hAA, 1'b0);
    pop_check("patt", 8'hAA);

    // Overflow: five bytes into a depth-4 FIFO
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    chk("full_level", {29'b0, fifo_level}, 32'd4);
    chk("full_ovf", {31'b0, overflow}, 32'd0);
    send_byte(8'h55, 1'b0);
    chk("ovf_level", {29'b0, fifo_level}, 32'd4);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    chk("ovf_head", {24'b0, byte_out}, 32'h11);
    // Push while full with a concurrent pop is accepted
    send_byte(8'h66, 1'b1);
    chk("simul_level", {29'b0, fifo_level}, 32'd4);
    chk("simul_ovf", {31'b0, overflow}, 32'd1);
    pop_check("rd0", 8'h22);
    pop_check("rd1", 8'h33);
    pop_check("rd2", 8'h44);
    pop_check("rd3", 8'h66);
    chk("drain_valid", {31'b0, byte_valid}, 32'd0);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    chk("empty_pop_level", {29'b0, fifo_level}, 32'd0);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);

    // Reset mid-operation: two bytes queued, five bits assembled, half pair pending
    send_byte(8'h0F, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_bits(8'hFF, 7, 3);
    word(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", {31'b0, byte_valid}, 32'd0);
    chk("mrst_level", {29'b0, fifo_level}, 32'd0);
    chk("mrst_ovf", {31'b0, overflow}, 32'd0);
    send_byte(8'hC3, 1'b0);
    pop_check("mrst_byte", 8'hC3);

    // Enable freeze mid-byte while a queued byte drains
    send_byte(8'h3C, 1'b0);
    send_bits(8'h5A, 7, 4);
    word(1'b1);
    chk("en_head", {24'b0, byte_out}, 32'h3C);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sum_in     = $urandom;
      sum_valid  = i[0];
      byte_ready = (i == 0);
      tick();
    end
    byte_ready = 1'b0;
    sum_valid  = 1'b0;
    en = 1'b1;
    chk("en_drained", {29'b0, fifo_level}, 32'd0);
    chk("en_cnt_frozen", {29'b0, dut.r_cnt}, 32'd4);
    word(1'b0);
    send_bits(8'h5A, 2, 0);
    chk("en_level", {29'b0, fifo_level}, 32'd1);
    pop_check("en_byte", 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
